syscall_io_unit: RTL and testbench
==================================

Name: syscall_io_unit

Overview:
- Serves the SYSCALL instruction. It sits directly downstream of the CPU controller: it consumes `runio`, ACC and DR, and returns `iobusy` and the word the controller muxes into ACC on the IO path.
- Decodes the syscall number held in ACC: halt, read word, or write word.
- Bridges to an external host through two valid/ready word streams, one input and one output.

Parameters:
- WIDTH, 16, data word width for ACC, DR, `io_result`, `in_data` and `out_data`.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- runio  in  1  syscall request from the controller; held high until `iobusy` is seen low.
- acc  in  WIDTH  syscall number, sampled at request start.
- dr  in  WIDTH  write-syscall argument, sampled at request start.
- iobusy  out  1  combinational; high while a request is pending and not complete.
- io_result  out  WIDTH  registered word from the last completed read; feeds the ACC IO mux.
- halted  out  1  sticky; set by the halt syscall.
- bad_syscall  out  1  sticky; set by an unknown syscall number.
- in_data  in  WIDTH  host input word.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  combinational; high in RD_WAIT.
- out_data  out  WIDTH  registered word being written.
- out_valid  out  1  combinational; high in WR_WAIT.
- out_ready  in  1  host accepts `out_data`.

Behaviour:
- Reset (reset=0, asynchronous), all registers cleared:
  - state=IDLE, `io_result`=0, `out_data`=0, `halted`=0, `bad_syscall`=0.
  - Outputs therefore: `iobusy`=`runio`, `in_ready`=0, `out_valid`=0.
- Syscall codes, on the full ACC value: 0 = HALT, 1 = READ, 2 = WRITE, anything else = unknown.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, HALT.
- `iobusy` = `runio` & (state != DONE).
  - It is combinational so it is high in the same cycle `runio` first rises. The controller samples it one edge after raising `runio`.
- IDLE:
  - `runio`=0: stay in IDLE.
  - `runio`=1, sample ACC on the next edge:
    - 0 → HALT; set `halted`.
    - 1 → RD_WAIT.
    - 2 → WR_WAIT; `out_data` <= `dr`.
    - other → DONE; set `bad_syscall`; no other side effect.
- RD_WAIT: `in_ready`=1. On an edge with `in_valid`=1: `io_result` <= `in_data`, go to DONE. Otherwise hold.
- WR_WAIT: `out_valid`=1. On an edge with `out_ready`=1: go to DONE. `out_data` stays stable until accepted.
- DONE:
  - `iobusy`=0.
  - Next edge → IDLE unconditionally. The controller drops `runio` on that same edge.
  - If `runio` is still 1 in the IDLE cycle that follows, that is a new request.
- HALT: terminal; `iobusy`=`runio`, so the CPU stalls forever. Only reset exits.
- Minimum latency, `runio` rise to `iobusy` low:
  - Read with `in_valid` already high, or write with `out_ready` already high: 2 edges.
  - Unknown code: 1 edge.
- `io_result` holds its value between reads; write, halt and unknown requests never change it.
- Boundary conditions:
  - `in_valid` or `out_ready` asserted outside the matching wait state is ignored; no transfer happens.
  - `runio` dropping mid-request (abnormal) does not abort the transaction; the FSM finishes its handshake.
  - An asynchronous reset in any state returns to IDLE immediately, drops `in_ready`/`out_valid` in that cycle, and clears the sticky flags.
  - No arithmetic; all widths are WIDTH with no truncation.

Decomposition:
- Shared definitions header, alongside the controller's constants:
  - syscall codes SYS_HALT=0, SYS_READ=1, SYS_WRITE=2;
  - FSM state encodings (3 bits).
- Single flat module; no natural sub-module. The FSM and the two handshakes are tightly coupled.

Test Plan:
- Read: reset; `runio`=1, ACC=1, `in_valid`=1, `in_data`=0x1234 → `in_ready` high one cycle; `io_result`=0x1234; `iobusy` low exactly 2 edges after `runio` rises; state back in IDLE after `runio` drops.
- Write with backpressure: ACC=2, DR=0xBEEF, `out_ready`=0 for 5 cycles then 1 → `out_valid` high 6 cycles with `out_data`=0xBEEF throughout; `iobusy` high until the accept edge; `io_result` unchanged.
- Halt: ACC=0 → `halted`=1, `iobusy` stays 1 for 100 cycles regardless of `in_valid`/`out_ready`; asserting reset clears `halted` and returns to IDLE.
- Unknown code: ACC=7 → `bad_syscall`=1 after 1 edge, `iobusy` low in the next cycle, no `in_ready`/`out_valid` pulse; a following ACC=1 read still completes.
- Back-to-back: read 0x0001, then write DR=0x0002, then read 0xFFFF, with controller-style `runio` timing → each completes in order; `io_result` ends at 0xFFFF; exactly one output transfer of 0x0002.
- Reset mid-read: ACC=1, `in_valid`=0, assert reset for 1 cycle → `in_ready` drops asynchronously, `io_result`=0, IDLE; a stale `in_valid` afterwards causes no capture.

Source files
------------

// File: rtl/syscall_io_unit_pkg.sv
// Shared constants for the SYSCALL IO unit: syscall codes, FSM encodings, decode.
package syscall_io_unit_pkg;

  localparam int unsigned SYS_HALT  = 0;
  localparam int unsigned SYS_READ  = 1;
  localparam int unsigned SYS_WRITE = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  typedef enum logic [1:0] {OP_HALT, OP_READ, OP_WRITE, OP_BAD} sys_op_e;

  // Decode works on the whole ACC: any set bit above bit 1 makes the code unknown.
  function automatic sys_op_e decode_op(input logic hi_zero, input logic [1:0] lo);
    sys_op_e op;
    op = OP_BAD;
    if (hi_zero) begin
      if (lo == 2'(SYS_HALT))       op = OP_HALT;
      else if (lo == 2'(SYS_READ))  op = OP_READ;
      else if (lo == 2'(SYS_WRITE)) op = OP_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/syscall_io_unit_if.sv
// Controller request/response plus host in/out word streams of the SYSCALL IO unit.
interface syscall_io_unit_if #(parameter int WIDTH = 16);
  logic             runio;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] dr;
  logic             iobusy;
  logic [WIDTH-1:0] io_result;
  logic             halted;
  logic             bad_syscall;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output runio, acc, dr, in_data, in_valid, out_ready,
    input  iobusy, io_result, halted, bad_syscall, in_ready, out_data, out_valid
  );

  modport slave (
    input  runio, acc, dr, in_data, in_valid, out_ready,
    output iobusy, io_result, halted, bad_syscall, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/syscall_io_unit.sv
// SYSCALL unit: decodes ACC on runio and runs halt, host read or host write.
module syscall_io_unit
  import syscall_io_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  syscall_io_unit_if.slave io
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] io_result_q, io_result_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             halted_q, halted_d;
  logic             bad_q, bad_d;
  sys_op_e          op;

  assign op = decode_op(~|io.acc[WIDTH-1:2], io.acc[1:0]);

  always_comb begin
    state_d     = state_q;
    io_result_d = io_result_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    bad_d       = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (io.runio) begin
          case (op)
            OP_HALT:  begin state_d = ST_HALT; halted_d = 1'b1; end
            OP_READ:  state_d = ST_RD_WAIT;
            OP_WRITE: begin state_d = ST_WR_WAIT; out_data_d = io.dr; end
            default:  begin state_d = ST_DONE; bad_d = 1'b1; end
          endcase
        end
      end
      ST_RD_WAIT: begin
        if (io.in_valid) begin
          io_result_d = io.in_data;
          state_d     = ST_DONE;
        end
      end
      ST_WR_WAIT: if (io.out_ready) state_d = ST_DONE;
      // One cycle with iobusy low lets the controller drop runio before we re-arm.
      ST_DONE:    state_d = ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      io_result_q <= '0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      io_result_q <= io_result_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
      bad_q       <= bad_d;
    end
  end

  assign io.iobusy      = io.runio & (state_q != ST_DONE);
  assign io.in_ready    = (state_q == ST_RD_WAIT);
  assign io.out_valid   = (state_q == ST_WR_WAIT);
  assign io.io_result   = io_result_q;
  assign io.out_data    = out_data_q;
  assign io.halted      = halted_q;
  assign io.bad_syscall = bad_q;

endmodule

// File: tb/tb_syscall_io_unit.sv
// Randomized self-checking bench for syscall_io_unit against a transaction-level model.
module tb_syscall_io_unit;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] exp_io;
  logic        exp_bad;
  logic [15:0] xfer_q[$];

  syscall_io_unit_if #(.WIDTH(16)) bus();

  syscall_io_unit #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected edges from runio rise to iobusy low, straight from the latency rules.
  function automatic int model_lat(input logic [15:0] a, input int dly);
    if (a == 16'd1 || a == 16'd2) return 1 + ((dly > 1) ? dly : 1);
    return 1;
  endfunction

  // Controller-style request: runio held until iobusy low, dropped on the next edge.
  // The host asserts in_valid/out_ready from cycle dly onward, whatever the op.
  task automatic run_sys(input logic [15:0] a, input logic [15:0] d, input logic [15:0] din,
                         input int dly, output int lat, output int in_cyc,
                         output int out_cyc, output int unstable);
    int k;
    bit done;
    k = 0; done = 0;
    lat = -1; in_cyc = 0; out_cyc = 0; unstable = 0;
    bus.runio = 1'b1; bus.acc = a; bus.dr = d; bus.in_data = din;
    while (!done && k < 300) begin
      bus.in_valid  = (k >= dly);
      bus.out_ready = (k >= dly);
      #1;
      if (!bus.iobusy) begin
        lat = k; done = 1;
      end else begin
        if (bus.in_ready) in_cyc++;
        if (bus.out_valid) begin
          out_cyc++;
          if (bus.out_data !== d) unstable++;
          if (bus.out_ready) xfer_q.push_back(bus.out_data);
        end
        @(posedge clock); #2; k++;
      end
    end
    @(posedge clock); #2;
    bus.runio = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.acc = 16'($urandom); bus.dr = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.runio = 1'b0; bus.acc = '0; bus.dr = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.io_result, bus.out_data} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got io_result=%h out_data=%h required 0/0", bus.io_result, bus.out_data);
    end
    n_checks++;
    if ({bus.halted, bus.bad_syscall, bus.in_ready, bus.out_valid, bus.iobusy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000",
        {bus.halted, bus.bad_syscall, bus.in_ready, bus.out_valid, bus.iobusy});
    end
    bus.runio = 1'b1;
    #1;
    n_checks++;
    if (bus.iobusy !== 1'b1) begin
      n_fail++; $display("FAIL reset_iobusy_follows_runio: got %b required 1", bus.iobusy);
    end
    bus.runio = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #2;
    exp_io = '0; exp_bad = 1'b0;
  endtask

  task automatic test_read();
    int lat, ic, oc, us;
    run_sys(16'd1, 16'($urandom), 16'h1234, 0, lat, ic, oc, us);
    exp_io = 16'h1234;
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d required 2", lat); end
    n_checks++;
    if (ic !== 1 || oc !== 0) begin
      n_fail++; $display("FAIL read_handshake: got in_ready=%0d out_valid=%0d cycles required 1/0", ic, oc);
    end
    n_checks++;
    if (bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL read_result: got %h required %h", bus.io_result, exp_io);
    end
    // Back in IDLE: stray host signals do nothing with runio low.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = 16'hDEAD;
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.iobusy} !== 3'b0 || bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL read_idle_after: got rdy/vld/busy=%b io_result=%h required 000/%h",
        {bus.in_ready, bus.out_valid, bus.iobusy}, bus.io_result, exp_io);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_write_bp();
    int lat, ic, oc, us;
    xfer_q.delete();
    run_sys(16'd2, 16'hBEEF, 16'h4444, 6, lat, ic, oc, us);
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL write_latency: got %0d required 7", lat); end
    n_checks++;
    if (oc !== 6 || ic !== 0 || us !== 0) begin
      n_fail++; $display("FAIL write_valid: got out_valid=%0d in_ready=%0d unstable=%0d required 6/0/0", oc, ic, us);
    end
    n_checks++;
    if (xfer_q.size() !== 1 || (xfer_q.size() == 1 && xfer_q[0] !== 16'hBEEF)) begin
      n_fail++; $display("FAIL write_xfer: got %0d transfers required 1 of beef", xfer_q.size());
    end
    n_checks++;
    if (bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL write_io_result: got %h required %h", bus.io_result, exp_io);
    end
  endtask

  task automatic test_halt();
    int bad_cyc, lat, ic, oc, us;
    bad_cyc = 0;
    bus.runio = 1'b1; bus.acc = 16'd0;
    @(posedge clock); #2;
    n_checks++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b required 1", bus.halted); end
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'($urandom); bus.out_ready = 1'($urandom); bus.in_data = 16'($urandom);
      #1;
      if (bus.iobusy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.io_result !== exp_io) bad_cyc++;
      @(posedge clock); #2;
    end
    n_checks++;
    if (bad_cyc !== 0) begin n_fail++; $display("FAIL halt_stall: got %0d bad cycles required 0", bad_cyc); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.halted !== 1'b0 || bus.iobusy !== 1'b1) begin
      n_fail++; $display("FAIL halt_reset: got halted=%b iobusy=%b required 0/1", bus.halted, bus.iobusy);
    end
    bus.runio = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #2;
    exp_io = '0; exp_bad = 1'b0;
    run_sys(16'd1, 16'h0, 16'h0F0F, 0, lat, ic, oc, us);
    exp_io = 16'h0F0F;
    n_checks++;
    if (lat !== 2 || bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL halt_recover_read: got lat=%0d io_result=%h required 2/%h", lat, bus.io_result, exp_io);
    end
  endtask

  task automatic test_unknown();
    int lat, ic, oc, us;
    run_sys(16'd7, 16'h1111, 16'h2222, 0, lat, ic, oc, us);
    exp_bad = 1'b1;
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL unknown_latency: got %0d required 1", lat); end
    n_checks++;
    if (ic !== 0 || oc !== 0 || bus.bad_syscall !== 1'b1 || bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL unknown_effects: got in=%0d out=%0d bad=%b io=%h required 0/0/1/%h",
        ic, oc, bus.bad_syscall, bus.io_result, exp_io);
    end
    run_sys(16'd1, 16'h0, 16'h5A5A, 2, lat, ic, oc, us);
    exp_io = 16'h5A5A;
    n_checks++;
    if (lat !== 3 || bus.io_result !== exp_io || bus.bad_syscall !== 1'b1) begin
      n_fail++; $display("FAIL unknown_then_read: got lat=%0d io=%h bad=%b required 3/%h/1",
        lat, bus.io_result, bus.bad_syscall, exp_io);
    end
  endtask

  task automatic test_back_to_back();
    int l0, l1, l2, ic, oc, us;
    xfer_q.delete();
    run_sys(16'd1, 16'h0, 16'h0001, 0, l0, ic, oc, us);
    run_sys(16'd2, 16'h0002, 16'h9999, 0, l1, ic, oc, us);
    run_sys(16'd1, 16'h0, 16'hFFFF, 0, l2, ic, oc, us);
    exp_io = 16'hFFFF;
    n_checks++;
    if (l0 !== 2 || l1 !== 2 || l2 !== 2) begin
      n_fail++; $display("FAIL b2b_latency: got %0d/%0d/%0d required 2/2/2", l0, l1, l2);
    end
    n_checks++;
    if (bus.io_result !== exp_io) begin
      n_fail++; $display("FAIL b2b_result: got %h required %h", bus.io_result, exp_io);
    end
    n_checks++;
    if (xfer_q.size() !== 1 || (xfer_q.size() == 1 && xfer_q[0] !== 16'h0002)) begin
      n_fail++; $display("FAIL b2b_xfer: got %0d transfers required 1 of 0002", xfer_q.size());
    end
  endtask

  task automatic test_random();
    int lat, ic, oc, us, kind, dly, n_wr, elat;
    logic [15:0] a, d, din;
    xfer_q.delete();
    n_wr = 0;
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 3));
      a = (kind == 1) ? 16'd2 : (kind == 2) ? 16'($urandom_range(3, 65535)) : 16'd1;
      d = 16'($urandom); din = 16'($urandom);
      dly = int'($urandom_range(0, 4));
      elat = model_lat(a, dly);
      run_sys(a, d, din, dly, lat, ic, oc, us);
      if (a == 16'd1) exp_io = din;
      if (a == 16'd2) n_wr++;
      if (a > 16'd2) exp_bad = 1'b1;
      n_checks++;
      if (lat !== elat || ic !== ((a == 16'd1) ? elat - 1 : 0) || oc !== ((a == 16'd2) ? elat - 1 : 0)) begin
        n_fail++; $display("FAIL rand_timing[%0d]: acc=%h dly=%0d got lat=%0d in=%0d out=%0d required lat=%0d",
          i, a, dly, lat, ic, oc, elat);
      end
      n_checks++;
      if (bus.io_result !== exp_io || bus.bad_syscall !== exp_bad || us !== 0) begin
        n_fail++; $display("FAIL rand_state[%0d]: got io=%h bad=%b unstable=%0d required %h/%b/0",
          i, bus.io_result, bus.bad_syscall, us, exp_io, exp_bad);
      end
      if (a == 16'd2) begin
        n_checks++;
        if (xfer_q.size() !== n_wr || (xfer_q.size() == n_wr && xfer_q[n_wr-1] !== d)) begin
          n_fail++; $display("FAIL rand_xfer[%0d]: got %0d transfers required %0d ending %h", i, xfer_q.size(), n_wr, d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int bad_cyc;
    bad_cyc = 0;
    bus.runio = 1'b1; bus.acc = 16'd1; bus.in_valid = 1'b0;
    @(posedge clock); #2;
    @(posedge clock); #2;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrd_wait: got in_ready=%b required 1", bus.in_ready); end
    reset = 1'b0;
    #1;
    exp_io = '0; exp_bad = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.io_result !== exp_io || bus.bad_syscall !== 1'b0) begin
      n_fail++; $display("FAIL midrd_reset: got rdy=%b vld=%b io=%h bad=%b required 0/0/0000/0",
        bus.in_ready, bus.out_valid, bus.io_result, bus.bad_syscall);
    end
    bus.runio = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 16'hABCD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #2;
      if (bus.in_ready !== 1'b0 || bus.io_result !== exp_io) bad_cyc++;
    end
    n_checks++;
    if (bad_cyc !== 0) begin n_fail++; $display("FAIL midrd_stale_valid: got %0d bad cycles required 0", bad_cyc); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_bp();
    test_halt();
    test_unknown();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
